ordered_multi_mode_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 23 ++
 rtl/ordered_multi_mode_arbiter_if.sv | 25 ++
 rtl/arb_order_queue.sv | 95 +++++++++
 rtl/ordered_multi_mode_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ordered_multi_mode_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the ordered multi-mode arbiter.
// Mode and state encodings plus a one-hot decoder.
package arb_pkg;

    localparam int ARB_MAX_N = 32;
    localparam int ARB_ID_W  = 5;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_RR    = 2'b01,
        MODE_FCFS  = 2'b10
    } arb_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [ARB_MAX_N-1:0] onehot_from_id(input logic [ARB_ID_W-1:0] id);
        onehot_from_id = {{(ARB_MAX_N-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/ordered_multi_mode_arbiter_if.sv
// Request/grant bundle between the shared-resource clients and the arbiter.
interface ordered_multi_mode_arbiter_if #(
    parameter int NUM_REQUESTS = 4
);
    localparam int IDW = $clog2(NUM_REQUESTS);

    logic [NUM_REQUESTS-1:0] rqst;
    logic [1:0]              mode;
    logic                    done;
    logic [NUM_REQUESTS-1:0] grant;
    logic                    grant_valid;
    logic [IDW-1:0]          grant_id;
    logic                    timeout;

    modport master (
        output rqst, mode, done,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  rqst, mode, done,
        output grant, grant_valid, grant_id, timeout
    );

endinterface

// File: rtl/arb_order_queue.sv
// Compacting arrival-order queue of requester IDs with per-requester queued bits.
// The head reflects this cycle's drops and arrivals so a lone new request wins without delay.
module arb_order_queue
    import arb_pkg::*;
#(
    parameter  int NUM_REQUESTS = 4,
    localparam int IDW          = $clog2(NUM_REQUESTS),
    localparam int CNTW         = $clog2(NUM_REQUESTS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQUESTS-1:0] rqst,
    input  logic [NUM_REQUESTS-1:0] enq_mask,
    input  logic [NUM_REQUESTS-1:0] rm_mask,
    output logic [IDW-1:0]          head_id,
    output logic                    head_valid
);

    logic [IDW-1:0]          ids_r [NUM_REQUESTS];
    logic [CNTW-1:0]         cnt_r;
    logic [NUM_REQUESTS-1:0] queued_r;

    logic [IDW-1:0]          mid_ids_s [NUM_REQUESTS];
    logic [CNTW-1:0]         mid_cnt_s;
    logic [IDW-1:0]          nxt_ids_s [NUM_REQUESTS];
    logic [CNTW-1:0]         nxt_cnt_s;
    logic [NUM_REQUESTS-1:0] nxt_queued_s;

    // Drop withdrawn entries, then append new arrivals in ascending index order
    always_comb begin : merge_blk
        int k;
        k = 0;
        for (int j = 0; j < NUM_REQUESTS; j++) begin
            mid_ids_s[j] = '0;
        end
        for (int j = 0; j < NUM_REQUESTS; j++) begin
            if ((j < int'(cnt_r)) && rqst[ids_r[j]]) begin
                mid_ids_s[IDW'(k)] = ids_r[j];
                k = k + 1;
            end else begin
                k = k;
            end
        end
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (enq_mask[i] && rqst[i] && !queued_r[i] && (k < NUM_REQUESTS)) begin
                mid_ids_s[IDW'(k)] = IDW'(i);
                k = k + 1;
            end else begin
                k = k;
            end
        end
        mid_cnt_s = CNTW'(k);
    end

    assign head_id    = mid_ids_s[0];
    assign head_valid = (mid_cnt_s != {CNTW{1'b0}});

    // Remove the entry granted this cycle and rebuild the queued bits
    always_comb begin : remove_blk
        int k;
        k            = 0;
        nxt_queued_s = '0;
        for (int j = 0; j < NUM_REQUESTS; j++) begin
            nxt_ids_s[j] = '0;
        end
        for (int j = 0; j < NUM_REQUESTS; j++) begin
            if ((j < int'(mid_cnt_s)) && !rm_mask[mid_ids_s[j]]) begin
                nxt_ids_s[IDW'(k)]          = mid_ids_s[j];
                nxt_queued_s[mid_ids_s[j]]  = 1'b1;
                k = k + 1;
            end else begin
                k = k;
            end
        end
        nxt_cnt_s = CNTW'(k);
    end

    // Queue storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_REQUESTS; j++) begin
                ids_r[j] <= '0;
            end
            cnt_r    <= '0;
            queued_r <= '0;
        end else begin
            for (int j = 0; j < NUM_REQUESTS; j++) begin
                ids_r[j] <= nxt_ids_s[j];
            end
            cnt_r    <= nxt_cnt_s;
            queued_r <= nxt_queued_s;
        end
    end

endmodule

// File: rtl/ordered_multi_mode_arbiter.sv
// N-way arbiter with fixed-priority, round-robin and first-come-first-served policies.
// Grants are held until done, withdrawal or hold timeout; one idle cycle separates grants.
module ordered_multi_mode_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQUESTS = 4,
    parameter  int MAX_HOLD     = 16,
    localparam int IDW          = $clog2(NUM_REQUESTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    ordered_multi_mode_arbiter_if.slave bus
);

    localparam int             CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]  HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [IDW-1:0] RR_INIT   = IDW'(NUM_REQUESTS - 1);

    arb_state_e              state_r, state_s;
    logic [IDW-1:0]          holder_r, holder_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    logic [IDW-1:0]          rr_ptr_r, rr_ptr_s;
    logic [NUM_REQUESTS-1:0] grant_r, grant_s;
    logic                    grant_valid_r, grant_valid_s;
    logic [IDW-1:0]          grant_id_r, grant_id_s;
    logic                    timeout_r, timeout_s;

    logic [IDW-1:0]          fixed_id_s;
    logic [IDW-1:0]          rr_id_s;
    logic [IDW-1:0]          winner_s;
    logic                    win_valid_s;
    logic [NUM_REQUESTS-1:0] win_onehot_s;
    logic [IDW-1:0]          head_id_s;
    logic                    head_valid_s;
    logic [NUM_REQUESTS-1:0] rm_mask_s;
    logic                    release_s;

    arb_order_queue #(
        .NUM_REQUESTS (NUM_REQUESTS)
    ) u_order_queue (
        .clk        (clk),
        .reset      (reset),
        .rqst       (bus.rqst),
        .enq_mask   (~grant_r),
        .rm_mask    (rm_mask_s),
        .head_id    (head_id_s),
        .head_valid (head_valid_s)
    );

    // Candidate winner for each policy and the one selected by mode
    always_comb begin : pick_blk
        int idx;
        idx         = 0;
        fixed_id_s  = '0;
        rr_id_s     = '0;
        winner_s    = '0;
        win_valid_s = 1'b0;
        // Descending scans leave the closest candidate as the final assignment
        for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
            if (bus.rqst[i]) begin
                fixed_id_s = IDW'(i);
            end else begin
                fixed_id_s = fixed_id_s;
            end
        end
        for (int k = NUM_REQUESTS; k >= 1; k--) begin
            idx = (int'(rr_ptr_r) + k) % NUM_REQUESTS;
            if (bus.rqst[IDW'(idx)]) begin
                rr_id_s = IDW'(idx);
            end else begin
                rr_id_s = rr_id_s;
            end
        end
        case (bus.mode)
            MODE_FIXED: begin
                winner_s    = fixed_id_s;
                win_valid_s = |bus.rqst;
            end
            MODE_RR: begin
                winner_s    = rr_id_s;
                win_valid_s = |bus.rqst;
            end
            default: begin
                winner_s    = head_id_s;
                win_valid_s = head_valid_s;
            end
        endcase
    end

    assign win_onehot_s = NUM_REQUESTS'(onehot_from_id(ARB_ID_W'(winner_s)));

    // Next-state, release decision and staging of registered outputs
    always_comb begin
        state_s       = state_r;
        holder_s      = holder_r;
        cnt_s         = cnt_r;
        rr_ptr_s      = rr_ptr_r;
        grant_s       = '0;
        grant_valid_s = 1'b0;
        grant_id_s    = '0;
        timeout_s     = 1'b0;
        rm_mask_s     = '0;
        release_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    state_s       = GRANT;
                    holder_s      = winner_s;
                    cnt_s         = '0;
                    rr_ptr_s      = winner_s;
                    grant_s       = win_onehot_s;
                    grant_valid_s = 1'b1;
                    grant_id_s    = winner_s;
                    rm_mask_s     = win_onehot_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                release_s = bus.done || !bus.rqst[holder_r] ||
                            ((MAX_HOLD > 0) && (cnt_r == HOLD_LAST));
                if (release_s) begin
                    state_s   = IDLE;
                    cnt_s     = '0;
                    // A done arriving with the limit wins, so no timeout pulse then
                    timeout_s = !bus.done && bus.rqst[holder_r];
                end else begin
                    cnt_s         = cnt_r + 1'b1;
                    grant_s       = grant_r;
                    grant_valid_s = 1'b1;
                    grant_id_s    = holder_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            holder_r      <= '0;
            cnt_r         <= '0;
            rr_ptr_r      <= RR_INIT;
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_id_r    <= '0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            holder_r      <= holder_s;
            cnt_r         <= cnt_s;
            rr_ptr_r      <= rr_ptr_s;
            grant_r       <= grant_s;
            grant_valid_r <= grant_valid_s;
            grant_id_r    <= grant_id_s;
            timeout_r     <= timeout_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_ordered_multi_mode_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_ordered_multi_mode_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ordered_multi_mode_arbiter_if #(.NUM_REQUESTS(N)) bus ();

    ordered_multi_mode_arbiter #(
        .NUM_REQUESTS (N),
        .MAX_HOLD     (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: arrival list, current holder, cycles held, RR pointer
    int           m_q[$];
    bit           m_busy;
    int           m_holder;
    int           m_held;
    int           m_ptr;
    logic [N-1:0] e_grant;
    logic         e_valid;
    logic [1:0]   e_id;
    logic         e_to;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_q(input int v);
        foreach (m_q[j]) begin
            if (m_q[j] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy   = 1'b0;
        m_holder = 0;
        m_held   = 0;
        m_ptr    = N - 1;
        e_grant  = '0;
        e_valid  = 1'b0;
        e_id     = 2'd0;
        e_to     = 1'b0;
    endtask

    task automatic model_cycle();
        logic [N-1:0] r;
        int keep[$];
        int w;
        bit found;
        r = bus.rqst;
        w = 0;
        found = 1'b0;
        foreach (m_q[j]) begin
            if (r[m_q[j]]) keep.push_back(m_q[j]);
        end
        m_q = keep;
        for (int i = 0; i < N; i++) begin
            if (r[i] && !(m_busy && i == m_holder) && !in_q(i)) m_q.push_back(i);
        end
        e_to = 1'b0;
        if (!m_busy) begin
            if (r != '0) begin
                if (bus.mode == 2'b00) begin
                    for (int i = 0; i < N; i++) begin
                        if (!found && r[i]) begin w = i; found = 1'b1; end
                    end
                end else if (bus.mode == 2'b01) begin
                    for (int k = 1; k <= N; k++) begin
                        if (!found && r[(m_ptr + k) % N]) begin w = (m_ptr + k) % N; found = 1'b1; end
                    end
                end else begin
                    w = m_q[0];
                end
                for (int j = 0; j < m_q.size(); j++) begin
                    if (m_q[j] == w) begin m_q.delete(j); break; end
                end
                m_busy   = 1'b1;
                m_holder = w;
                m_held   = 0;
                m_ptr    = w;
            end
        end else begin
            m_held++;
            if (bus.done || !r[m_holder] || m_held == MAX_HOLD) begin
                e_to   = !bus.done && r[m_holder];
                m_busy = 1'b0;
            end
        end
        e_grant = m_busy ? N'(1 << m_holder) : '0;
        e_valid = m_busy;
        e_id    = m_busy ? 2'(m_holder) : 2'd0;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        check_value("grant",       32'(bus.grant),       32'(e_grant));
        check_value("grant_valid", 32'(bus.grant_valid), 32'(e_valid));
        check_value("grant_id",    32'(bus.grant_id),    32'(e_id));
        check_value("timeout",     32'(bus.timeout),     32'(e_to));
    endtask

    // Raises reset between edges so the zero outputs prove asynchronous clearing
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_value("rst_grant",   32'(bus.grant),       32'd0);
        check_value("rst_valid",   32'(bus.grant_valid), 32'd0);
        check_value("rst_id",      32'(bus.grant_id),    32'd0);
        check_value("rst_timeout", 32'(bus.timeout),     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int saw3;
        int n;
        int got[$];
        logic [N-1:0] rr_seq [5];
        logic [N-1:0] rr_exp [5];

        bus.rqst = '0;
        bus.mode = 2'b00;
        bus.done = 1'b0;
        #2;

        // Fixed priority: index 1 always beats index 3
        do_reset();
        bus.mode = 2'b00;
        bus.rqst = 4'b1010;
        saw3 = 0;
        for (int c = 0; c < 12; c++) begin
            bus.done = m_busy;
            tick();
            if (bus.grant[3]) saw3 = 1;
        end
        check_value("fixed_never3", 32'(saw3), 32'd0);

        // Round-robin rotation from index 0
        do_reset();
        bus.mode = 2'b01;
        bus.rqst = 4'b1111;
        bus.done = 1'b0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (n < 5) begin
                bus.done = m_busy;
                tick();
                if (bus.grant_valid) begin
                    rr_seq[n] = bus.grant;
                    n++;
                end
            end
        end
        check_value("rr_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_value($sformatf("rr_seq%0d", i), 32'(rr_seq[i]), 32'(rr_exp[i]));
        end

        // FCFS: staggered arrivals 2, 0, 3
        do_reset();
        bus.mode = 2'b10;
        bus.done = 1'b0;
        bus.rqst = 4'b0100; tick();
        got.delete();
        got.push_back(int'(bus.grant_id));
        bus.rqst = 4'b0101; tick();
        bus.rqst = 4'b1101; tick();
        for (int c = 0; c < 20; c++) begin
            if (got.size() < 3) begin
                bus.done = m_busy;
                tick();
                if (bus.grant_valid) got.push_back(int'(bus.grant_id));
            end
        end
        check_value("fcfs_count", 32'(got.size()), 32'd3);
        check_value("fcfs_first",  32'(got[0]), 32'd2);
        check_value("fcfs_second", 32'(got.size() > 1 ? got[1] : -1), 32'd0);
        check_value("fcfs_third",  32'(got.size() > 2 ? got[2] : -1), 32'd3);

        // FCFS: same-cycle arrivals 1 and 3 go in ascending order
        do_reset();
        bus.mode = 2'b10;
        bus.done = 1'b0;
        bus.rqst = 4'b0000; tick();
        bus.rqst = 4'b1010; tick();
        check_value("same_first", 32'(bus.grant_id), 32'd1);
        bus.done = 1'b1; tick();
        bus.done = 1'b0; tick();
        check_value("same_second", 32'(bus.grant_id), 32'd3);

        // Hold timeout with a waiting requester
        do_reset();
        bus.mode = 2'b10;
        bus.done = 1'b0;
        bus.rqst = 4'b0010; tick();
        check_value("to_g1", 32'(bus.grant), 32'h2);
        bus.rqst = 4'b0110;
        repeat (3) tick();
        check_value("to_held", 32'(bus.grant), 32'h2);
        tick();
        check_value("to_pulse", 32'(bus.timeout), 32'd1);
        check_value("to_idle",  32'(bus.grant), 32'd0);
        tick();
        check_value("to_next", 32'(bus.grant), 32'h4);
        bus.done = 1'b1; tick();
        bus.done = 1'b0; tick();
        check_value("to_back", 32'(bus.grant), 32'h2);

        // Withdrawal of a queued requester and of the holder
        do_reset();
        bus.mode = 2'b10;
        bus.done = 1'b0;
        bus.rqst = 4'b0010; tick();
        bus.rqst = 4'b0110; tick();
        bus.rqst = 4'b0111; tick();
        bus.rqst = 4'b0011;
        bus.done = 1'b1; tick();
        bus.done = 1'b0; tick();
        check_value("wd_skip", 32'(bus.grant_id), 32'd0);
        bus.rqst = 4'b0010; tick();
        check_value("wd_no_to",  32'(bus.timeout),     32'd0);
        check_value("wd_release", 32'(bus.grant_valid), 32'd0);
        tick();
        check_value("wd_regrant", 32'(bus.grant_id), 32'd1);

        // Reset while a grant is held, requests kept high across it
        do_reset();
        bus.mode = 2'b10;
        bus.done = 1'b0;
        bus.rqst = 4'b1010; tick();
        tick();
        do_reset();
        tick();
        check_value("rst_regrant", 32'(bus.grant), 32'h2);
        bus.done = 1'b1; tick();
        bus.done = 1'b0; tick();
        check_value("rst_second", 32'(bus.grant), 32'h8);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 31) == 0) bus.mode = 2'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                if (bus.rqst[i]) begin
                    if ($urandom_range(0, 11) == 0) bus.rqst[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) bus.rqst[i] = 1'b1;
                end
            end
            bus.done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
